pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage core (IF/ID/EX/MEM/WB).
//  - Tracks dest-register info for EX/MEM/WB in its own shadow pipeline.
//  - Issues load-use stalls and per-operand forward selects for NUM_SRC sources.
//  - Predicts not-taken; on a redirect it kills only the wrong-path instructions,
//    so the front end no longer freezes while a branch is in flight.
//  - Sits beside the datapath and drives its pipeline-register enables/bubbles.

---
 rtl/pipe_hazard_pkg.sv | 30 +++
 rtl/pipe_hazard_ctrl_if.sv | 46 ++++
 rtl/pipe_fwd_cmp.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_pkg.sv
// ============================================================================
// Module  : pipe_hazard_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_pkg;

  localparam int BR_EX    = 2;
  localparam int BR_MEM   = 3;
  // Shadow stages store rd at this fixed width so one struct serves any REG_ADDR_W.
  localparam int RD_W_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rd;
    logic                reg_write;
    logic                is_load;
  } stage_info_t;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : ID-stage decode info and redirect in, pipeline control out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 3,
  parameter int PERF_W     = 16
);
  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0]            id_src_used;
  logic [REG_ADDR_W-1:0]         id_rd;
  logic                          id_reg_write;
  logic                          id_is_load;
  logic                          id_jump;
  logic                          redirect;

  logic                          pc_en;
  logic                          ifid_en;
  logic                          ifid_flush;
  logic                          idex_bubble;
  logic                          exmem_bubble;
  logic [NUM_SRC*2-1:0]          fwd_sel;
  logic [PERF_W-1:0]             stall_cnt;
  logic [PERF_W-1:0]             flush_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_rd, id_reg_write, id_is_load,
           id_jump, redirect,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_bubble, fwd_sel,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rd, id_reg_write, id_is_load,
           id_jump, redirect,
    output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_bubble, fwd_sel,
           stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_fwd_cmp.sv
// ============================================================================
// Module  : pipe_fwd_cmp
// Brief   : Forward select for one EX source against the MEM and WB stages.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_fwd_cmp
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  used,
  input  stage_info_t           mem,
  input  stage_info_t           wb,
  output fwd_sel_e              sel
);

  logic [RD_W_MAX-1:0] w_src;
  logic                w_mem_hit;
  logic                w_wb_hit;

  assign w_src = RD_W_MAX'(src);

  // A load in MEM has no data yet; that case is covered by the load-use stall.
  assign w_mem_hit = mem.valid && mem.reg_write && !mem.is_load &&
                     (mem.rd != '0) && (mem.rd == w_src);
  assign w_wb_hit  = wb.valid && wb.reg_write &&
                     (wb.rd != '0) && (wb.rd == w_src);

  always_comb begin
    sel = FWD_RF;
    if (used) begin
      if (w_mem_hit)     sel = FWD_MEM;
      else if (w_wb_hit) sel = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Load-use stall, forwarding and redirect-kill control for a 5-stage
//           pipeline. Optional perf counters under PIPE_HAZARD_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 3,
  parameter int BR_STAGE   = 3,
  parameter int PERF_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam logic C_KILL_MEM = (BR_STAGE == BR_MEM);

  if ((BR_STAGE != BR_EX) && (BR_STAGE != BR_MEM)) begin : g_bad_br_stage
    $error("pipe_hazard_ctrl: BR_STAGE must be 2 (EX) or 3 (MEM)");
  end
  if (REG_ADDR_W > RD_W_MAX) begin : g_bad_addr_w
    $error("pipe_hazard_ctrl: REG_ADDR_W exceeds RD_W_MAX");
  end

  stage_info_t                   r_ex;
  stage_info_t                   r_mem;
  stage_info_t                   r_wb;
  logic [NUM_SRC*REG_ADDR_W-1:0] r_ex_src;
  logic [NUM_SRC-1:0]            r_ex_used;

  logic [NUM_SRC-1:0]            w_hit;
  logic                          w_load_use;
  fwd_sel_e                      w_sel [NUM_SRC];

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_hit[i] = hz.id_src_used[i] &&
                 (hz.id_src[i*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                 (RD_W_MAX'(hz.id_src[i*REG_ADDR_W +: REG_ADDR_W]) == r_ex.rd);
    end
  end

  assign w_load_use = hz.id_valid && r_ex.valid && r_ex.is_load &&
                      r_ex.reg_write && (|w_hit);

  always_comb begin
    hz.pc_en        = 1'b1;
    hz.ifid_en      = 1'b1;
    hz.ifid_flush   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.exmem_bubble = 1'b0;
    if (reset) begin
      hz.pc_en        = 1'b0;
      hz.ifid_en      = 1'b0;
      hz.ifid_flush   = 1'b1;
      hz.idex_bubble  = 1'b1;
      hz.exmem_bubble = 1'b1;
    end else if (hz.redirect) begin
      // Kill everything younger than the resolving branch, never the branch.
      hz.ifid_flush   = 1'b1;
      hz.idex_bubble  = 1'b1;
      hz.exmem_bubble = C_KILL_MEM;
    end else if (w_load_use) begin
      hz.pc_en        = 1'b0;
      hz.ifid_en      = 1'b0;
      hz.idex_bubble  = 1'b1;
    end else if (hz.id_jump) begin
      hz.ifid_flush   = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    pipe_fwd_cmp #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp (
      .src  (r_ex_src[g*REG_ADDR_W +: REG_ADDR_W]),
      .used (r_ex_used[g]),
      .mem  (r_mem),
      .wb   (r_wb),
      .sel  (w_sel[g])
    );
  end

  always_comb begin
    hz.fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hz.fwd_sel[2*i +: 2] = reset ? 2'b00 : w_sel[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex      <= '0;
      r_mem     <= '0;
      r_wb      <= '0;
      r_ex_src  <= '0;
      r_ex_used <= '0;
    end else begin
      if (hz.idex_bubble || !hz.id_valid) begin
        r_ex      <= '0;
        r_ex_src  <= '0;
        r_ex_used <= '0;
      end else begin
        r_ex.valid     <= 1'b1;
        r_ex.rd        <= RD_W_MAX'(hz.id_rd);
        r_ex.reg_write <= hz.id_reg_write;
        r_ex.is_load   <= hz.id_is_load;
        r_ex_src       <= hz.id_src;
        r_ex_used      <= hz.id_src_used;
      end
      r_mem <= hz.exmem_bubble ? '0 : r_ex;
      r_wb  <= r_mem;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_load_use && !hz.redirect && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (hz.ifid_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Drives a BR_STAGE=3 and a BR_STAGE=2 controller in lockstep and
//           compares both against a stage-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic            valid;
    logic [2:0][4:0] src;
    logic [2:0]      used;
    logic [4:0]      rd;
    logic            rw;
    logic            ld;
    logic            jump;
    logic            redirect;
  } in_t;

  typedef struct packed {
    logic            pc_en;
    logic            ifid_en;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            exmem_bubble;
    logic [2:0][1:0] fwd;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  typedef struct packed {
    logic            v;
    logic [4:0]      rd;
    logic            rw;
    logic            ld;
    logic [2:0][4:0] src;
    logic [2:0]      used;
  } ins_t;

  logic clk = 1'b0;
  logic rst_r = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .NUM_SRC(3), .PERF_W(16)) ifa ();
  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .NUM_SRC(3), .PERF_W(4))  ifb ();

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .NUM_SRC(3), .BR_STAGE(3), .PERF_W(16)) dut_a (
    .clk   (clk),
    .reset (rst_r),
    .hz    (ifa)
  );
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .NUM_SRC(3), .BR_STAGE(2), .PERF_W(4)) dut_b (
    .clk   (clk),
    .reset (rst_r),
    .hz    (ifb)
  );

  out_t        act_o [2];
  logic [15:0] act_sc [2];
  logic [15:0] act_fc [2];
  assign act_o[0]  = {ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idex_bubble, ifa.exmem_bubble, ifa.fwd_sel};
  assign act_o[1]  = {ifb.pc_en, ifb.ifid_en, ifb.ifid_flush, ifb.idex_bubble, ifb.exmem_bubble, ifb.fwd_sel};
  assign act_sc[0] = ifa.stall_cnt;
  assign act_fc[0] = ifa.flush_cnt;
  assign act_sc[1] = {12'd0, ifb.stall_cnt};
  assign act_fc[1] = {12'd0, ifb.flush_cnt};

  int n_tot  = 0;
  int n_pass = 0;

  // Reference model: instructions sitting in stages EX(2), MEM(3), WB(4).
  ins_t m_ex [2];
  ins_t m_mem [2];
  ins_t m_wb [2];
  int   m_stall [2];
  int   m_flush [2];
  int   br_stage [2] = '{3, 2};
  int   perf_w [2]   = '{16, 4};

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  function automatic in_t mk(bit v, int s0, int s1, int s2, bit [2:0] u,
                             int rd, bit rw, bit ld, bit j, bit r);
    in_t x;
    x.valid = v;   x.src[0] = s0[4:0]; x.src[1] = s1[4:0]; x.src[2] = s2[4:0];
    x.used = u;    x.rd = rd[4:0];     x.rw = rw;          x.ld = ld;
    x.jump = j;    x.redirect = r;
    return x;
  endfunction

  function automatic out_t mo(bit pc, bit ie, bit fl, bit bu, bit eb, bit [5:0] f);
    out_t o;
    o.pc_en = pc; o.ifid_en = ie; o.ifid_flush = fl; o.idex_bubble = bu;
    o.exmem_bubble = eb; o.fwd = f;
    return o;
  endfunction

  function automatic out_t exp_out(int d, in_t x, bit r);
    out_t o;
    bit   lu;
    bit   found;
    ins_t prod [2];
    o = '0;
    if (r) begin
      o.ifid_flush = 1'b1; o.idex_bubble = 1'b1; o.exmem_bubble = 1'b1;
      return o;
    end
    prod[0] = m_mem[d];
    prod[1] = m_wb[d];
    lu = 1'b0;
    for (int i = 0; i < 3; i++)
      if (x.valid && x.used[i] && x.src[i] != 0 && m_ex[d].v && m_ex[d].ld &&
          m_ex[d].rw && m_ex[d].rd == x.src[i]) lu = 1'b1;
    for (int i = 0; i < 3; i++) begin
      found = 1'b0;
      if (m_ex[d].used[i])
        for (int k = 0; k < 2; k++)
          if (!found && prod[k].v && prod[k].rw && prod[k].rd != 0 &&
              prod[k].rd == m_ex[d].src[i] && !(k == 0 && prod[k].ld)) begin
            o.fwd[i] = (k == 0) ? 2'b10 : 2'b01;
            found = 1'b1;
          end
    end
    if (x.redirect) begin
      // Only stages younger than the branch die; EX (stage 2) is younger iff branch is later.
      o = mo(1, 1, 1, 1, (2 < br_stage[d]), o.fwd);
    end else if (lu) o = mo(0, 0, 0, 1, 0, o.fwd);
    else if (x.jump) o = mo(1, 1, 1, 0, 0, o.fwd);
    else o = mo(1, 1, 0, 0, 0, o.fwd);
    return o;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ex[d] = '0; m_mem[d] = '0; m_wb[d] = '0; m_stall[d] = 0; m_flush[d] = 0;
    end
  endfunction

  function automatic void advance(int d, in_t x, out_t o);
    int sat;
    sat = (1 << perf_w[d]) - 1;
    m_wb[d]  = m_mem[d];
    m_mem[d] = o.exmem_bubble ? '0 : m_ex[d];
    if (o.idex_bubble || !x.valid) m_ex[d] = '0;
    else m_ex[d] = {1'b1, x.rd, x.rw, x.ld, x.src, x.used};
    if (!o.pc_en && m_stall[d] < sat) m_stall[d]++;
    if (o.ifid_flush && m_flush[d] < sat) m_flush[d]++;
  endfunction

  task automatic drive(in_t x);
    ifa.id_valid = x.valid; ifa.id_src = x.src; ifa.id_src_used = x.used;
    ifa.id_rd = x.rd; ifa.id_reg_write = x.rw; ifa.id_is_load = x.ld;
    ifa.id_jump = x.jump; ifa.redirect = x.redirect;
    ifb.id_valid = x.valid; ifb.id_src = x.src; ifb.id_src_used = x.used;
    ifb.id_rd = x.rd; ifb.id_reg_write = x.rw; ifb.id_is_load = x.ld;
    ifb.id_jump = x.jump; ifb.redirect = x.redirect;
  endtask

  task automatic compare(int d, out_t e, string tag);
    string s;
    int    es;
    int    ef;
    s = $sformatf("%s_%s", tag, (d == 0) ? "a" : "b");
    chk({s, "_ctrl"}, int'(act_o[d][10:6]), int'(e[10:6]));
    chk({s, "_fwd"}, int'(act_o[d].fwd), int'(e.fwd));
`ifdef PIPE_HAZARD_PERF_EN
    es = m_stall[d]; ef = m_flush[d];
`else
    es = 0; ef = 0;
`endif
    chk({s, "_stall_cnt"}, int'(act_sc[d]), es);
    chk({s, "_flush_cnt"}, int'(act_fc[d]), ef);
  endtask

  task automatic step(in_t x, string tag, bit use_t, out_t texp);
    out_t e [2];
    drive(x);
    #2;
    if (use_t) chk({tag, "_tbl"}, int'(act_o[0]), int'(texp));
    for (int d = 0; d < 2; d++) begin
      e[d] = exp_out(d, x, rst_r);
      compare(d, e[d], tag);
    end
    @(posedge clk);
    if (!rst_r) for (int d = 0; d < 2; d++) advance(d, x, e[d]);
    @(negedge clk);
  endtask

  function automatic in_t rand_in();
    in_t x;
    x.valid = ($urandom % 8) != 0;
    for (int i = 0; i < 3; i++) x.src[i] = 5'($urandom_range(0, 3));
    x.used = 3'($urandom);
    x.rd = 5'($urandom_range(0, 3));
    x.rw = 1'($urandom);
    x.ld = ($urandom % 3) == 0;
    x.jump = ($urandom % 10) == 0;
    x.redirect = ($urandom % 10) == 0;
    return x;
  endfunction

  vec_t vecs[$];
  in_t  nop;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    nop = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    // ALU chain, rd=0 producer, load-use, jump vs load-use, redirect+jump+load-use.
    vecs.push_back({mk(1, 1, 2, 0, 3'b011, 5, 1, 0, 0, 0),   mo(1, 1, 0, 0, 0, 6'b000000)});
    vecs.push_back({mk(1, 5, 5, 0, 3'b011, 6, 1, 0, 0, 0),   mo(1, 1, 0, 0, 0, 6'b000000)});
    vecs.push_back({mk(1, 5, 0, 0, 3'b011, 9, 1, 0, 0, 0),   mo(1, 1, 0, 0, 0, 6'b001010)});
    vecs.push_back({mk(1, 3, 3, 0, 3'b011, 0, 1, 0, 0, 0),   mo(1, 1, 0, 0, 0, 6'b000001)});
    vecs.push_back({mk(1, 0, 0, 0, 3'b011, 11, 1, 0, 0, 0),  mo(1, 1, 0, 0, 0, 6'b000000)});
    vecs.push_back({nop,                                      mo(1, 1, 0, 0, 0, 6'b000000)});
    vecs.push_back({mk(1, 1, 0, 0, 3'b001, 7, 1, 1, 0, 0),   mo(1, 1, 0, 0, 0, 6'b000000)});
    vecs.push_back({mk(1, 7, 1, 0, 3'b011, 8, 1, 0, 0, 0),   mo(0, 0, 0, 1, 0, 6'b000000)});
    vecs.push_back({mk(1, 7, 1, 0, 3'b011, 8, 1, 0, 0, 0),   mo(1, 1, 0, 0, 0, 6'b000000)});
    vecs.push_back({nop,                                      mo(1, 1, 0, 0, 0, 6'b000001)});
    vecs.push_back({mk(1, 0, 0, 0, 3'b000, 12, 1, 1, 0, 0),  mo(1, 1, 0, 0, 0, 6'b000000)});
    vecs.push_back({mk(1, 12, 0, 0, 3'b001, 31, 1, 0, 1, 0), mo(0, 0, 0, 1, 0, 6'b000000)});
    vecs.push_back({mk(1, 12, 0, 0, 3'b001, 31, 1, 0, 1, 0), mo(1, 1, 1, 0, 0, 6'b000000)});
    vecs.push_back({nop,                                      mo(1, 1, 0, 0, 0, 6'b000001)});
    vecs.push_back({mk(1, 1, 0, 0, 3'b001, 13, 1, 1, 0, 0),  mo(1, 1, 0, 0, 0, 6'b000000)});
    vecs.push_back({mk(1, 13, 0, 0, 3'b001, 14, 1, 0, 1, 1), mo(1, 1, 1, 1, 1, 6'b000000)});
    vecs.push_back({nop,                                      mo(1, 1, 0, 0, 0, 6'b000000)});

    // Power-on reset values.
    model_reset();
    drive(nop);
    #2;
    for (int d = 0; d < 2; d++) compare(d, exp_out(d, nop, 1'b1), "por");
    @(negedge clk);
    @(negedge clk);
    rst_r = 1'b0;

    foreach (vecs[i]) step(vecs[i].in, $sformatf("vec%0d", i), 1'b1, vecs[i].exp);

    // Redirect with younger instructions in flight.
    for (int i = 0; i < 3; i++) step(nop, "drain", 1'b0, '0);
    step(mk(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0), "br", 1'b0, '0);
    step(mk(1, 0, 0, 0, 3'b000, 20, 1, 0, 0, 0), "y1", 1'b0, '0);
    drive(mk(1, 0, 0, 0, 3'b000, 21, 1, 0, 0, 1));
    #2;
    chk("redir_a_exmem_bubble", int'(act_o[0].exmem_bubble), 1);
    chk("redir_b_exmem_bubble", int'(act_o[1].exmem_bubble), 0);
    chk("redir_a_pc_en", int'(act_o[0].pc_en), 1);
    @(negedge clk);
    rst_r = 1'b0;
    // Re-run that cycle through the model so its state follows the DUTs.
    begin
      out_t e0, e1;
      in_t  xr;
      xr = mk(1, 0, 0, 0, 3'b000, 21, 1, 0, 0, 1);
      e0 = exp_out(0, xr, 1'b0);
      e1 = exp_out(1, xr, 1'b0);
      advance(0, xr, e0);
      advance(1, xr, e1);
    end
    step(mk(1, 20, 21, 0, 3'b011, 22, 1, 0, 0, 0), "cons", 1'b0, '0);
    drive(nop);
    #2;
    chk("killed_no_fwd_a", int'(act_o[0].fwd), 0);
    @(negedge clk);
    begin
      out_t e0, e1;
      e0 = exp_out(0, nop, 1'b0);
      e1 = exp_out(1, nop, 1'b0);
      advance(0, nop, e0);
      advance(1, nop, e1);
    end

    // Asynchronous reset between edges with a load in EX.
    step(mk(1, 1, 0, 0, 3'b001, 7, 1, 1, 0, 0), "lw_pre_rst", 1'b0, '0);
    drive(mk(1, 7, 1, 0, 3'b011, 8, 1, 0, 0, 0));
    #1;
    chk("pre_rst_stall", int'(act_o[0].pc_en), 0);
    rst_r = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) compare(d, exp_out(d, nop, 1'b1), "mid_rst");
    @(negedge clk);
    rst_r = 1'b0;
    drive(mk(1, 7, 1, 0, 3'b011, 8, 1, 0, 0, 0));
    #2;
    chk("post_rst_no_stall", int'(act_o[0].pc_en), 1);
    @(negedge clk);
    step(mk(1, 7, 1, 0, 3'b011, 8, 1, 0, 0, 0), "post_rst", 1'b0, '0);
    step(nop, "post_rst_fwd", 1'b0, '0);

    for (int c = 0; c < 400; c++) step(rand_in(), "rnd", 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
